pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Decides each cycle which pipeline registers hold, which get bubbled, and which get flushed, for: load-use hazards, taken branches, multicycle MUL/DIV in EX, and data-bus wait states in MEM.
- Sits beside the forwarding logic. Forwarding resolves ALU-to-ALU hazards; this block covers everything forwarding cannot.

Parameters:
- CNT_W, 32, width of the stall-cycle performance counter.
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before forced release; 0 disables the timeout.
- TO_W, 8, width of the wait counter; must satisfy MEM_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_rd  in  5  destination register of the EX instruction.
- ex_mem_read  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- ex_muldiv_start  in  1  a multicycle MUL/DIV is in EX this cycle.
- ex_muldiv_done  in  1  MUL/DIV result valid; level, held until accepted.
- mem_req  in  1  MEM stage issues a data-bus access.
- mem_ack  in  1  data bus completes the access.
- stall_pc  out  1  hold the PC.
- stall_if_id  out  1  hold the IF/ID register.
- stall_id_ex  out  1  hold the ID/EX register.
- stall_ex_mem  out  1  hold the EX/MEM register.
- flush_if_id  out  1  load a NOP into IF/ID.
- flush_id_ex  out  1  load a bubble into ID/EX.
- bubble_ex_mem  out  1  load a bubble into EX/MEM.
- mem_timeout  out  1  one-cycle pulse on forced MEM_WAIT release.
- state_o  out  2  current state: 0 RUN, 1 MULDIV, 2 MEM_WAIT.
- stall_cycles  out  CNT_W  count of cycles with stall_pc=1; saturating.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state returns to RUN; wait_cnt=0; stall_cycles=0.
  - All stall, flush and bubble outputs and mem_timeout are forced to 0 while rst_n=0, including mid-MULDIV and mid-MEM_WAIT.
- Output timing: outputs are combinational from the registered state and current inputs, so they act in the same cycle. State and counters update on the rising clk edge.
- Definitions used below:
  - memstall = mem_req & ~mem_ack.
  - lu (load-use) = ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, conditions evaluated in strict priority order:
  1. memstall: assert stall_pc, stall_if_id, stall_id_ex, stall_ex_mem. Clear wait_cnt. Next state MEM_WAIT.
  2. branch_taken: assert flush_if_id and flush_id_ex, no stalls. Remain in RUN. Overrides lu and ex_muldiv_start.
  3. ex_muldiv_start & ~ex_muldiv_done: assert stall_pc, stall_if_id, stall_id_ex, bubble_ex_mem. Next state MULDIV.
  4. lu: assert stall_pc, stall_if_id, flush_id_ex for exactly that cycle. The bubble makes ex_valid=0 on the next cycle, so the stall self-terminates after 1 cycle; forwarding then covers the load.
  5. Otherwise: all outputs 0.
  - ex_muldiv_start & ex_muldiv_done in the same cycle: no stall, remain in RUN.
- MULDIV:
  - While ex_muldiv_done=0: assert stall_pc, stall_if_id, stall_id_ex, bubble_ex_mem.
  - If memstall occurs here: additionally assert stall_ex_mem and suppress bubble_ex_mem.
  - Exit: ex_muldiv_done=1 and no memstall releases all stalls that cycle (the result is accepted) and moves to RUN.
  - ex_muldiv_done=1 together with memstall: keep all four stalls and stay in MULDIV; the result stays held.
  - branch_taken is ignored in this state.
- MEM_WAIT:
  - While mem_ack=0: assert all four stalls and increment wait_cnt.
  - mem_ack=1: release all stalls that cycle and move to RUN.
  - Timeout: MEM_TIMEOUT!=0, mem_ack=0 and wait_cnt==MEM_TIMEOUT-1. Release the stalls, pulse mem_timeout for 1 cycle, move to RUN. Total stall length on timeout = 1 RUN cycle + MEM_TIMEOUT MEM_WAIT cycles.
  - branch_taken and lu are ignored here; they are re-evaluated in RUN because EX and ID were frozen.
- stall_cycles: +1 on every clk edge where stall_pc=1. Saturates at all-ones, never wraps.
- The encoding value 3 for state_o is unreachable; if it is ever reached, the next state is RUN.

Test Plan:
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID → exactly 1 cycle of stall_pc=stall_if_id=flush_id_ex=1, next cycle all 0, stall_cycles=1. Same sequence with ex_rd=0 → no stall.
- Branch vs load-use: branch_taken=1 with lu=1 in the same cycle → flush_if_id=flush_id_ex=1, stall_pc=0, state_o stays 0.
- MUL/DIV: ex_muldiv_start=1, ex_muldiv_done rises 5 cycles later → stall_pc and bubble_ex_mem high for 5 cycles, released in the done cycle, state_o 0→1→0, stall_cycles=5.
- Bus wait: mem_req=1, mem_ack=0 for 3 cycles, then ack → stall_ex_mem high for 3 cycles, released in the ack cycle, no mem_timeout.
- Timeout: MEM_TIMEOUT=4, mem_ack never arrives → stalls high for 5 cycles, mem_timeout pulses once in the 5th cycle, state_o returns to 0.
- Reset mid-MULDIV: drop rst_n while state_o=1 → all outputs 0 immediately, state_o=0 and stall_cycles=0 with no clock edge needed.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: covers load-use, taken branches,
// multicycle MUL/DIV in EX and data-bus wait states in MEM.
module pipeline_hazard_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             ex_muldiv_start,
  input  logic             ex_muldiv_done,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             bubble_ex_mem,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MULDIV  = 2'd1,
    S_MEMWAIT = 2'd2
  } state_t;

  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic memstall, lu, to_hit;
  logic s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, b_exmem, to_pulse;

  assign memstall = mem_req & ~mem_ack;
  assign lu = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign to_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == TO_W'(TO_LAST));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    s_pc       = 1'b0;
    s_ifid     = 1'b0;
    s_idex     = 1'b0;
    s_exmem    = 1'b0;
    f_ifid     = 1'b0;
    f_idex     = 1'b0;
    b_exmem    = 1'b0;
    to_pulse   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (memstall) begin
          {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
          wait_cnt_d = '0;
          state_d    = S_MEMWAIT;
        end else if (branch_taken) begin
          f_ifid = 1'b1;
          f_idex = 1'b1;
        end else if (ex_muldiv_start && !ex_muldiv_done) begin
          {s_pc, s_ifid, s_idex, b_exmem} = 4'b1111;
          state_d = S_MULDIV;
        end else if (lu) begin
          // One bubble clears ex_valid next cycle, so this stall ends by itself.
          {s_pc, s_ifid, f_idex} = 3'b111;
        end
      end
      S_MULDIV: begin
        if (!ex_muldiv_done || memstall) begin
          {s_pc, s_ifid, s_idex} = 3'b111;
          // A stalled MEM must keep its instruction rather than take a bubble.
          s_exmem = memstall;
          b_exmem = ~memstall;
        end else begin
          state_d = S_RUN;
        end
      end
      S_MEMWAIT: begin
        if (mem_ack) begin
          state_d = S_RUN;
        end else begin
          {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
          if (to_hit) begin
            to_pulse   = 1'b1;
            wait_cnt_d = '0;
            state_d    = S_RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Reset must silence the pipeline controls even before any clock edge.
  assign stall_pc      = rst_n & s_pc;
  assign stall_if_id   = rst_n & s_ifid;
  assign stall_id_ex   = rst_n & s_idex;
  assign stall_ex_mem  = rst_n & s_exmem;
  assign flush_if_id   = rst_n & f_ifid;
  assign flush_id_ex   = rst_n & f_idex;
  assign bubble_ex_mem = rst_n & b_exmem;
  assign mem_timeout   = rst_n & to_pulse;
  assign state_o       = state_q;
  assign stall_cycles  = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (s_pc && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: single-cycle RUN vectors from a
// table plus hand-written multi-cycle sequences (MUL/DIV, bus wait, timeout, reset).
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read;
  logic        branch_taken, ex_muldiv_start, ex_muldiv_done, mem_req, mem_ack;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic        flush_if_id, flush_id_ex, bubble_ex_mem, mem_timeout;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles;
  logic [6:0]  outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.CNT_W(32), .MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .ex_muldiv_start(ex_muldiv_start),
    .ex_muldiv_done(ex_muldiv_done), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .bubble_ex_mem(bubble_ex_mem), .mem_timeout(mem_timeout),
    .state_o(state_o), .stall_cycles(stall_cycles)
  );

  // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, bubble_ex_mem}
  assign outs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                 flush_if_id, flush_id_ex, bubble_ex_mem};

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ev;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       st;
    logic       dn;
    logic       rq;
    logic       ak;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_mem_read = 0; branch_taken = 0;
    ex_muldiv_start = 0; ex_muldiv_done = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_valid = v.ev; ex_rd = v.rd; ex_mem_read = v.mr; branch_taken = v.br;
    ex_muldiv_start = v.st; ex_muldiv_done = v.dn; mem_req = v.rq; mem_ack = v.ak;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rs1    rs2    u1 u2 ev rd     mr br st dn rq ak exp
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 7'b0000000}; // idle
    vecs[1]  = '{5'd5, 5'd1, 1, 1, 1, 5'd5, 1, 0, 0, 0, 0, 0, 7'b1100010}; // lu on rs1
    vecs[2]  = '{5'd3, 5'd7, 1, 1, 1, 5'd7, 1, 0, 0, 0, 0, 0, 7'b1100010}; // lu on rs2
    vecs[3]  = '{5'd5, 5'd1, 0, 1, 1, 5'd5, 1, 0, 0, 0, 0, 0, 7'b0000000}; // rs1 not read
    vecs[4]  = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 0, 0, 0, 0, 0, 7'b0000000}; // x0 dest
    vecs[5]  = '{5'd5, 5'd1, 1, 1, 0, 5'd5, 1, 0, 0, 0, 0, 0, 7'b0000000}; // EX bubble
    vecs[6]  = '{5'd5, 5'd1, 1, 1, 1, 5'd5, 0, 0, 0, 0, 0, 0, 7'b0000000}; // not a load
    vecs[7]  = '{5'd5, 5'd1, 1, 1, 1, 5'd5, 1, 1, 0, 0, 0, 0, 7'b0000110}; // branch beats lu
    vecs[8]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0, 0, 0, 7'b0000110}; // branch beats muldiv
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0, 7'b0000000}; // start & done
    vecs[10] = '{5'd9, 5'd9, 1, 0, 1, 5'd9, 1, 0, 1, 1, 0, 0, 7'b1100010}; // start&done, lu
    vecs[11] = '{5'd4, 5'd2, 0, 1, 1, 5'd2, 1, 0, 0, 0, 1, 1, 7'b1100010}; // bus acked, lu

    clear_inputs();
    rst_n = 1'b0;
    id_rs1 = 5'd5; id_uses_rs1 = 1; ex_valid = 1; ex_rd = 5'd5; ex_mem_read = 1;
    mem_req = 1;
    #3;
    chk("reset_outs", {25'd0, outs}, 32'd0);
    chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("reset_state", {30'd0, state_o}, 32'd0);
    chk("reset_cnt", stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    do_reset();
    @(negedge clk);
    id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs1 = 1; id_uses_rs2 = 1;
    ex_valid = 1; ex_rd = 5'd5; ex_mem_read = 1;
    #1 chk("lu_stall", {25'd0, outs}, {25'd0, 7'b1100010});
    @(negedge clk);
    ex_valid = 0;
    #1 chk("lu_after", {25'd0, outs}, 32'd0);
    chk("lu_cnt", stall_cycles, 32'd1);
    @(negedge clk);
    ex_valid = 1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #1 chk("lu_x0", {25'd0, outs}, 32'd0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d_outs", i), {25'd0, outs}, {25'd0, vecs[i].exp});
      chk($sformatf("vec%0d_to", i), {31'd0, mem_timeout}, 32'd0);
      @(posedge clk);
      #1 chk($sformatf("vec%0d_state", i), {30'd0, state_o}, 32'd0);
    end

    // MUL/DIV: done rises 5 cycles after start
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ex_muldiv_start = (i == 0);
      #1;
      chk($sformatf("md%0d_outs", i), {25'd0, outs}, {25'd0, 7'b1110001});
      chk($sformatf("md%0d_state", i), {30'd0, state_o}, (i == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    ex_muldiv_done = 1;
    #1 chk("md_done_outs", {25'd0, outs}, 32'd0);
    chk("md_done_state", {30'd0, state_o}, 32'd1);
    @(negedge clk);
    ex_muldiv_done = 0;
    #1 chk("md_exit_state", {30'd0, state_o}, 32'd0);
    chk("md_cnt", stall_cycles, 32'd5);

    // MUL/DIV with a bus stall in MEM, including done arriving during it
    do_reset();
    @(negedge clk);
    ex_muldiv_start = 1;
    @(negedge clk);
    ex_muldiv_start = 0; mem_req = 1;
    #1 chk("md_mem_outs", {25'd0, outs}, {25'd0, 7'b1111000});
    @(negedge clk);
    ex_muldiv_done = 1;
    #1 chk("md_mem_done_outs", {25'd0, outs}, {25'd0, 7'b1111000});
    @(negedge clk);
    mem_ack = 1;
    #1 chk("md_mem_state", {30'd0, state_o}, 32'd1);
    chk("md_mem_rel_outs", {25'd0, outs}, 32'd0);

    // Bus wait: 3 cycles without ack, then ack
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_req = 1;
      #1;
      chk($sformatf("bw%0d_outs", i), {25'd0, outs}, {25'd0, 7'b1111000});
      chk($sformatf("bw%0d_to", i), {31'd0, mem_timeout}, 32'd0);
    end
    @(negedge clk);
    mem_ack = 1;
    #1 chk("bw_ack_outs", {25'd0, outs}, 32'd0);
    chk("bw_ack_to", {31'd0, mem_timeout}, 32'd0);
    @(negedge clk);
    mem_req = 0; mem_ack = 0;
    #1 chk("bw_state", {30'd0, state_o}, 32'd0);
    chk("bw_cnt", stall_cycles, 32'd3);

    // Timeout: ack never arrives, MEM_TIMEOUT=4
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_req = 1;
      #1;
      chk($sformatf("to%0d_stall", i), {31'd0, stall_ex_mem & stall_pc}, 32'd1);
      chk($sformatf("to%0d_pulse", i), {31'd0, mem_timeout}, (i == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    mem_req = 0;
    #1 chk("to_state", {30'd0, state_o}, 32'd0);
    chk("to_after", {31'd0, mem_timeout}, 32'd0);
    chk("to_cnt", stall_cycles, 32'd5);

    // Reset in the middle of MULDIV, inputs still demanding a stall
    do_reset();
    @(negedge clk);
    ex_muldiv_start = 1;
    @(negedge clk);
    mem_req = 1;
    #1 chk("rmd_state", {30'd0, state_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rmd_outs", {25'd0, outs}, 32'd0);
    chk("rmd_state0", {30'd0, state_o}, 32'd0);
    chk("rmd_cnt", stall_cycles, 32'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
